// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - OPB-mapped frequency meter counting CLK_MEAS edges over a gated window
//
// Purpose : counts rising edges of an asynchronous clock under test over a
//           window of max(GATE,1) x GATE_UNIT OPB_CLK cycles. The result,
//           overflow, valid and sequence status are published on a 4-bit
//           OPB register map.
// Ports   : OPB_CLK/OPB_RST_N  sole clock, asynchronous active-low reset
//           OPB_ADDR/DI/WE/RE  register access (one-cycle write strobe)
//           OPB_DO             read data, high-Z unless RE and address decoded
//           CLK_MEAS           clock under test (< OPB_CLK/2)
//           BUSY               high while a window is armed, open or latching
//           IRQ                VALID & CTRL.IE, present only with CLK_METER_IRQ_EN
// Macro   : CLK_METER_IRQ_EN adds IRQ and a stored CTRL.IE bit.
// Map     : 0x0 CTRL {IE,CLR,START,EN}, 0x1 GATE, 0x2 COUNT, 0x3 STATUS
module clk_freq_meter #(
  parameter int          CNT_W     = 24,
  parameter int          GATE_UNIT = 100,
  parameter logic [15:0] GATE_DFLT = 16'd1000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic [3:0]  OPB_ADDR,
  input  logic [15:0] OPB_DI,
  input  logic        OPB_WE,
  input  logic        OPB_RE,
  output logic [31:0] OPB_DO,
  input  logic        CLK_MEAS,
`ifdef CLK_METER_IRQ_EN
  output logic        IRQ,
`endif
  output logic        BUSY
);

  localparam int             PW       = (GATE_UNIT > 1) ? $clog2(GATE_UNIT) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(GATE_UNIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_GATE, ST_LATCH} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              en_q;
  logic              oneshot_q;
  logic [15:0]       gate_q, shadow_q, tick_q;
  logic [PW-1:0]     pre_q;
  logic [CNT_W-1:0]  cnt_q, result_q;
  logic              ovf_run_q, ovf_q, valid_q, carry_q;
  logic [7:0]        seq_q;
`ifdef CLK_METER_IRQ_EN
  logic              ie_q, irq_q;
`endif

  logic wr_ctrl, wr_gate, start_wr, clr_wr, edge_pulse, last_tick, abort;
  logic        rd_hit;
  logic [31:0] rd_data, count_ext;

  assign wr_ctrl    = OPB_WE && (OPB_ADDR == 4'h0);
  assign wr_gate    = OPB_WE && (OPB_ADDR == 4'h1);
  assign start_wr   = wr_ctrl && OPB_DI[1];
  assign clr_wr     = wr_ctrl && OPB_DI[2];
  assign edge_pulse = s2_q & ~s3_q;
  assign last_tick  = (pre_q == PRE_LAST) && (tick_q == shadow_q - 16'd1);
  // A window only survives EN=0 if it was launched by a START write.
  assign abort      = !en_q && !oneshot_q;
  assign BUSY       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en_q || start_wr) state_d = ST_ARM;
      ST_ARM:   state_d = abort ? ST_IDLE : ST_GATE;
      ST_GATE:  if (abort) state_d = ST_IDLE;
                else if (last_tick) state_d = ST_LATCH;
      ST_LATCH: state_d = en_q ? ST_ARM : ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      gate_q    <= GATE_DFLT;
      shadow_q  <= 16'd1;
      tick_q    <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ovf_run_q <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      carry_q   <= 1'b0;
      seq_q     <= '0;
`ifdef CLK_METER_IRQ_EN
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s1_q    <= CLK_MEAS;
      s2_q    <= s1_q;
      s3_q    <= s2_q;

      if (wr_ctrl) en_q <= OPB_DI[0];
      if (wr_gate) gate_q <= OPB_DI;
`ifdef CLK_METER_IRQ_EN
      if (wr_ctrl) ie_q <= OPB_DI[3];
      irq_q <= clr_wr ? 1'b0 : (valid_q & ie_q);
`endif
      // CLR is applied first so a coincident LATCH below overrides it.
      if (clr_wr) begin
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          carry_q <= 1'b0;
          if (start_wr) oneshot_q <= 1'b1;
        end
        ST_ARM: begin
          pre_q     <= '0;
          tick_q    <= '0;
          ovf_run_q <= 1'b0;
          carry_q   <= 1'b0;
          shadow_q  <= (gate_q == 16'd0) ? 16'd1 : gate_q;
          // An edge from LATCH or this cycle opens the new window at 1.
          cnt_q     <= CNT_W'(edge_pulse | carry_q);
        end
        ST_GATE: begin
          if (pre_q == PRE_LAST) begin
            pre_q  <= '0;
            tick_q <= tick_q + 16'd1;
          end else begin
            pre_q <= pre_q + 1'b1;
          end
          if (edge_pulse) begin
            if (cnt_q == CNT_MAX) ovf_run_q <= 1'b1;
            else cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LATCH: begin
          result_q  <= cnt_q;
          ovf_q     <= ovf_run_q;
          valid_q   <= 1'b1;
          seq_q     <= seq_q + 8'd1;
          carry_q   <= edge_pulse;
          oneshot_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_METER_IRQ_EN
  assign IRQ = irq_q;
`endif

  always_comb begin
    rd_data   = '0;
    rd_hit    = 1'b1;
    count_ext = '0;
    count_ext[CNT_W-1:0] = result_q;
    case (OPB_ADDR)
      4'h0: begin
        rd_data[0] = en_q;
`ifdef CLK_METER_IRQ_EN
        rd_data[3] = ie_q;
`endif
      end
      4'h1: rd_data[15:0] = gate_q;
      4'h2: rd_data = count_ext;
      4'h3: begin
        rd_data[0]    = valid_q;
        rd_data[1]    = ovf_q;
        rd_data[2]    = BUSY;
        rd_data[15:8] = seq_q;
      end
      default: rd_hit = 1'b0;
    endcase
  end

  assign OPB_DO = (OPB_RE && rd_hit) ? rd_data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - scoreboard bench for clk_freq_meter
module tb_clk_freq_meter;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST_N;
  logic [3:0]  OPB_ADDR;
  logic [15:0] OPB_DI;
  logic        we1, re1, we2, re2;
  wire  [31:0] do1, do2;
  logic        CLK_MEAS, CLK_MEAS2;
  wire         busy1, busy2;
`ifdef CLK_METER_IRQ_EN
  wire         irq1, irq2;
`endif

  always #5 OPB_CLK = ~OPB_CLK;

  clk_freq_meter #(.CNT_W(24), .GATE_UNIT(100), .GATE_DFLT(16'd1000)) u_dut (
    .OPB_CLK(OPB_CLK), .OPB_RST_N(OPB_RST_N), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
    .OPB_WE(we1), .OPB_RE(re1), .OPB_DO(do1), .CLK_MEAS(CLK_MEAS),
`ifdef CLK_METER_IRQ_EN
    .IRQ(irq1),
`endif
    .BUSY(busy1));

  clk_freq_meter #(.CNT_W(8), .GATE_UNIT(100), .GATE_DFLT(16'd1000)) u_ovf (
    .OPB_CLK(OPB_CLK), .OPB_RST_N(OPB_RST_N), .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI),
    .OPB_WE(we2), .OPB_RE(re2), .OPB_DO(do2), .CLK_MEAS(CLK_MEAS2),
`ifdef CLK_METER_IRQ_EN
    .IRQ(irq2),
`endif
    .BUSY(busy2));

  typedef struct {
    logic [31:0] exp;
    int          tol;
    bit          cmp;
    bit          acc;
    bit          sum_chk;
    longint      sum_exp;
    bit          want_z;
    string       name;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     seq_m  = 0;

  // Clock-under-test generator: period in OPB_CLK cycles, free-running or a counted burst.
  int meas_per   = 0;
  int meas_burst = 0;
  int meas_ph    = 0;
  bit meas_free  = 1'b1;

  initial begin
    CLK_MEAS = 1'b0;
    forever begin
      @(posedge OPB_CLK);
      #3;
      if (meas_per > 0 && (meas_free || meas_burst > 0 || meas_ph != 0)) begin
        if (meas_ph == 0) begin
          CLK_MEAS = 1'b1;
          if (!meas_free) meas_burst--;
        end else if (meas_ph == meas_per / 2) begin
          CLK_MEAS = 1'b0;
        end
        meas_ph = (meas_ph + 1) % meas_per;
      end else begin
        CLK_MEAS = 1'b0;
        meas_ph  = 0;
      end
    end
  end

  // Second meter sees a clock of period 2 OPB_CLK cycles to force saturation.
  initial begin
    CLK_MEAS2 = 1'b0;
    #3;
    forever #10 CLK_MEAS2 = ~CLK_MEAS2;
  end

  int run_len  = 0;
  int last_len = 0;
  always @(negedge OPB_CLK) begin
    if (busy1 === 1'b1) run_len++;
    else begin
      if (run_len != 0) last_len = run_len;
      run_len = 0;
    end
  end

  // Monitor: every OPB read cycle pops one expectation.
  exp_t        mon_e;
  logic [31:0] mon_act;
  longint      mon_d;
  longint      mon_sum = 0;
  always @(negedge OPB_CLK) begin
    if (re1 || re2) begin
      mon_act = re1 ? do1 : do2;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %h required no pending read", mon_act);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.want_z) begin
          checks++;
          if (mon_act !== 32'hzzzz_zzzz) begin
            errors++;
            $display("FAIL %s: got %h required all Z", mon_e.name, mon_act);
          end
        end else begin
          mon_d = longint'(mon_act) - longint'(mon_e.exp);
          if (mon_d < 0) mon_d = -mon_d;
          if (mon_e.cmp) begin
            checks++;
            if ($isunknown(mon_act) || mon_d > mon_e.tol) begin
              errors++;
              $display("FAIL %s: got %0d (0x%h) required %0d (0x%h) +/-%0d",
                       mon_e.name, mon_act, mon_act, mon_e.exp, mon_e.exp, mon_e.tol);
            end
          end
          if (mon_e.acc) mon_sum += longint'(mon_act);
          if (mon_e.sum_chk) begin
            checks++;
            if (mon_sum != mon_e.sum_exp) begin
              errors++;
              $display("FAIL %s_sum: got %0d required %0d", mon_e.name, mon_sum, mon_e.sum_exp);
            end
            mon_sum = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, ex);
    end
  endtask

  task automatic wr(input int unit, input logic [3:0] a, input logic [15:0] d);
    @(posedge OPB_CLK); #1;
    OPB_ADDR = a; OPB_DI = d;
    if (unit == 0) we1 = 1'b1; else we2 = 1'b1;
    @(posedge OPB_CLK); #1;
    we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd(input int unit, input logic [3:0] a, input logic [31:0] ex, input int tol,
                    input bit cmp, input bit acc, input bit sc, input longint sx,
                    input bit wz, input string nm);
    exp_t e;
    e.exp = ex; e.tol = tol; e.cmp = cmp; e.acc = acc; e.sum_chk = sc;
    e.sum_exp = sx; e.want_z = wz; e.name = nm;
    sb_q.push_back(e);
    @(posedge OPB_CLK); #1;
    OPB_ADDR = a;
    if (unit == 0) re1 = 1'b1; else re2 = 1'b1;
    @(posedge OPB_CLK); #1;
    re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic rdc(input int unit, input logic [3:0] a, input logic [31:0] ex,
                     input int tol, input string nm);
    rd(unit, a, ex, tol, 1'b1, 1'b0, 1'b0, 0, 1'b0, nm);
  endtask

  function automatic logic [31:0] st(input int seq, input bit v, input bit o, input bit b);
    logic [7:0] s8;
    s8 = 8'(seq % 256);
    return {16'h0, s8, 5'b0, b, o, v};
  endfunction

  task automatic wait_idle(input int unit, input int limit, input string nm);
    int c = 0;
    while (((unit == 0) ? busy1 : busy2) !== 1'b0 && c < limit) begin
      @(negedge OPB_CLK);
      c++;
    end
    checks++;
    if (c >= limit) begin
      errors++;
      $display("FAIL %s_timeout: BUSY high after %0d cycles, required low", nm, c);
    end
    #1;
  endtask

  task automatic oneshot(input int g, input int p, input bit restart);
    int win;
    win = ((g == 0) ? 1 : g) * 100;
    meas_per = p; meas_free = 1'b1;
    wr(0, 4'h1, 16'(g));
    rdc(0, 4'h1, 32'(g), 0, "gate_readback");
    repeat (5) @(posedge OPB_CLK);
    last_len = 0;
    wr(0, 4'h0, 16'h0002);
    if (restart) begin
      repeat (20) @(posedge OPB_CLK);
      wr(0, 4'h0, 16'h0002);
    end
    wait_idle(0, win + 50, "oneshot");
    seq_m++;
    chk("busy_len", 32'(last_len), 32'(win + 2));
    rdc(0, 4'h2, 32'(win / p), 1, "oneshot_count");
    rdc(0, 4'h3, st(seq_m, 1, 0, 0), 0, "oneshot_status");
    rdc(0, 4'h0, 32'h0, 0, "ctrl_selfclear");
  endtask

  initial begin
    OPB_RST_N = 1'b0; OPB_ADDR = '0; OPB_DI = '0;
    we1 = 1'b0; re1 = 1'b0; we2 = 1'b0; re2 = 1'b0;
    repeat (3) @(posedge OPB_CLK);
    @(negedge OPB_CLK); OPB_RST_N = 1'b1;

    // Reset state and unmapped address
    chk("reset_busy", {31'b0, busy1}, 32'h0);
    rdc(0, 4'h3, 32'h0, 0, "reset_status");
    rdc(0, 4'h2, 32'h0, 0, "reset_count");
    rdc(0, 4'h1, 32'd1000, 0, "reset_gate");
    rdc(0, 4'h0, 32'h0, 0, "reset_ctrl");
    rd(0, 4'h5, 32'h0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, "unmapped_5");

    // One-shot windows: nominal, then randomized including GATE=0 and START while busy
    oneshot(10, 10, 1'b0);
    for (int i = 0; i < 3; i++)
      oneshot((i == 0) ? 0 : int'($urandom_range(1, 3)), int'($urandom_range(3, 9)), i == 1);

    // Continuous mode with a counted burst: no edge lost across window boundaries
    begin
      int base;
      meas_per = 0;
      repeat (10) @(posedge OPB_CLK);
      wr(0, 4'h1, 16'd5);
      base = seq_m;
      wr(0, 4'h0, 16'h0001);
      meas_free = 1'b0; meas_burst = 480; meas_per = 4;
      repeat (753) @(posedge OPB_CLK);
      for (int n = 1; n <= 4; n++) begin
        rd(0, 4'h2, 32'd125, 1, (n == 2 || n == 3), 1'b1, (n == 4), 480, 1'b0, "cont_count");
        rdc(0, 4'h3, st(base + n, 1, 0, 1), 0, "cont_status");
        repeat (498) @(posedge OPB_CLK);
      end
      seq_m = base + 5;
      rdc(0, 4'h2, 32'h0, 0, "cont_quiet_count");
      rdc(0, 4'h3, st(seq_m, 1, 0, 1), 0, "cont_quiet_status");

      // Abort mid-window: result, VALID and SEQ stay as they were
      meas_free = 1'b1; meas_per = 5;
      repeat (100) @(posedge OPB_CLK);
      wr(0, 4'h0, 16'h0000);
      @(posedge OPB_CLK); @(negedge OPB_CLK);
      chk("abort_busy", {31'b0, busy1}, 32'h0);
      meas_per = 0;
      repeat (600) @(posedge OPB_CLK);
      rdc(0, 4'h2, 32'h0, 0, "abort_count");
      rdc(0, 4'h3, st(seq_m, 1, 0, 0), 0, "abort_status");
    end

    // CLR landing on the LATCH edge loses to LATCH
    wr(0, 4'h1, 16'd1);
    wr(0, 4'h0, 16'h0002);
    repeat (100) @(posedge OPB_CLK);
    wr(0, 4'h0, 16'h0004);
    seq_m++;
    rdc(0, 4'h3, st(seq_m, 1, 0, 0), 0, "clr_vs_latch");
    rdc(0, 4'h2, 32'h0, 0, "clr_vs_latch_count");
    wr(0, 4'h0, 16'h0004);
    rdc(0, 4'h3, st(seq_m, 0, 0, 0), 0, "clr_status");

    // Narrow counter saturates
    wr(1, 4'h1, 16'd10);
    wr(1, 4'h0, 16'h0002);
    wait_idle(1, 1100, "ovf_window");
    rdc(1, 4'h2, 32'd255, 0, "ovf_count");
    rdc(1, 4'h3, st(1, 1, 1, 0), 0, "ovf_status");
    wr(1, 4'h0, 16'h0004);
    rdc(1, 4'h3, st(1, 0, 0, 0), 0, "ovf_clr_status");

    // IE bit storage and interrupt timing
    wr(0, 4'h0, 16'h0008);
`ifdef CLK_METER_IRQ_EN
    rdc(0, 4'h0, 32'h8, 0, "ctrl_ie");
    wr(0, 4'h1, 16'd1);
    wr(0, 4'h0, 16'h000A);
    repeat (101) @(posedge OPB_CLK);
    @(negedge OPB_CLK); chk("irq_before_latch", {31'b0, irq1}, 32'h0);
    @(negedge OPB_CLK); chk("irq_at_valid", {31'b0, irq1}, 32'h0);
    @(negedge OPB_CLK); chk("irq_rise", {31'b0, irq1}, 32'h1);
    seq_m++;
    wr(0, 4'h0, 16'h000C);
    @(negedge OPB_CLK); chk("irq_clr", {31'b0, irq1}, 32'h0);
    wr(0, 4'h0, 16'h000A);
`else
    rdc(0, 4'h0, 32'h0, 0, "ctrl_ie");
    wr(0, 4'h1, 16'd10);
    wr(0, 4'h0, 16'h0002);
`endif

    // Asynchronous reset in the middle of a window
    meas_free = 1'b1; meas_per = 7;
    wr(0, 4'h1, 16'd10);
    repeat (50) @(posedge OPB_CLK);
    chk("pre_reset_busy", {31'b0, busy1}, 32'h1);
    #2 OPB_RST_N = 1'b0;
    #1 chk("async_reset_busy", {31'b0, busy1}, 32'h0);
`ifdef CLK_METER_IRQ_EN
    chk("async_reset_irq", {31'b0, irq1}, 32'h0);
`endif
    repeat (2) @(negedge OPB_CLK);
    OPB_RST_N = 1'b1;
    seq_m = 0;
    rdc(0, 4'h3, 32'h0, 0, "post_reset_status");
    rdc(0, 4'h2, 32'h0, 0, "post_reset_count");
    rdc(0, 4'h1, 32'd1000, 0, "post_reset_gate");
    rdc(0, 4'h0, 32'h0, 0, "post_reset_ctrl");

    repeat (3) @(posedge OPB_CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
